bias_fetch_sched: RTL and testbench
===================================

# bias_fetch_sched

Sequencer for the 128-entry, 4-read-port bias ROM (`regfile2`). On `start` it walks the ROM in groups of four consecutive biases, up to a programmed neuron count. It drives the four ROM read addresses and registers each 128-bit group into an output stage with a valid/ready handshake. It sits between the layer controller and the accumulator/bias-add stage.

## Interface
- `DEPTH`, 128: ROM entries.
- `LANES`, 4: biases per beat; equals the ROM read-port count.
- `AW`, 7: ROM address width.
- `DW`, 32: bias width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch a fetch run; sampled only in IDLE.
- `abort`  in  1  cancel the current run; no `done`.
- `n_out`  in  8  biases to fetch, latched at `start`; values above 128 clamp to 128.
- `rom_a1`..`rom_a4`  out  AW each  ROM read addresses for lanes 0..3.
- `rom_bias`  in  LANES*DW  combinational ROM data; lane k is at [32k+31:32k].
- `bias_out`  out  LANES*DW  registered bias group.
- `bias_mask`  out  LANES  per-lane valid bits for `bias_out`.
- `bias_valid`  out  1  `bias_out` holds a beat.
- `bias_ready`  in  1  downstream accepts the beat.
- `bias_last`  out  1  the current beat is the final beat of the run.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when a run completes.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE:**
  - `start`=1 latches `min(n_out,128)` into `cnt` and clears `base`.
  - If `cnt`=0, pulse `done` on the next cycle and stay in IDLE.
  - Otherwise go to RUN.
- **RUN, addresses:** lane k address = `base+k` when `base+k < cnt`, else 0 (always a legal address).
- **RUN, load rule:** the output stage loads when it is free, i.e. `!bias_valid || bias_ready`. A load does the following:
  - `bias_out` lane k = `rom_bias` lane k when `base+k < cnt`, else 0.
  - `bias_mask`[k] = (`base+k < cnt`).
  - `bias_valid`=1.
  - `bias_last` = (`base+4 >= cnt`).
  - `base += 4`.
- **RUN, last load:** when `base+4 >= cnt`, go to DRAIN.
- **DRAIN:** wait for the handshake `bias_valid && bias_ready` with `bias_last`=1. On that edge:
  - `bias_valid`=0.
  - `done` pulses on the following cycle.
  - Return to IDLE.
- **Handshake in RUN:** a handshake on a non-last beat and a load of the next beat happen on the same edge. This gives 1 beat/cycle with no bubbles.
- **Run length:** beats = ceil(cnt/4). Lanes are filled in order, so `bias_mask` is always 1111, 0111, 0011 or 0001 (lane 0 = LSB).
- **Back-pressure:** while `bias_valid && !bias_ready`:
  - `bias_out`, `bias_mask` and `bias_last` hold stable.
  - `base` and the ROM addresses hold.
- **Bias data:** passed through unmodified (two's complement); no arithmetic on data.
- **`start` while busy:** ignored.
- **`abort`:** in any state, on the next edge go to IDLE with `bias_valid`=0, `bias_mask`=0, `bias_last`=0, `base`=0 and no `done`. If `abort` and `start` are both high in IDLE, `abort` wins.
- **Reset:** `rst` takes effect asynchronously and clears all registers. An in-flight beat is dropped.

## Timing
- **Reset values:**
  - state IDLE.
  - `bias_out`=0, `bias_mask`=0.
  - `bias_valid`=0, `bias_last`=0.
  - `busy`=0, `done`=0.
  - `rom_a1`..`rom_a4`=0.
  - `base`=0, `cnt`=0.
- **Start latency:** `start` at edge T puts the FSM in RUN after T. The first beat loads at edge T+1, so `bias_valid` is first high in cycle T+1..T+2.
- **Data path:** ROM addresses are combinational from `base` and `cnt`. The ROM read is combinational. The only register on the data path is `bias_out`.
- **`done`:** asserted exactly one cycle, the cycle after the last handshake; `busy` falls in that same cycle.
- **`n_out`=0:** `done` in cycle T+1, `busy` never asserts.
- **Cycle count:** with `bias_ready` held high, `n_out`=128 takes 32 consecutive valid cycles, and `done` falls 34 cycles after `start`.

## Test plan
- **Full run:** `n_out`=128, `bias_ready`=1 ->
  - 32 back-to-back beats, all masks 1111.
  - Beat 0 lanes 0..3 = FFFFFCA3, FFFFFA81, 000000CF, 0000014C.
  - Beat 31 = FFFFFC3A, FFFFFBA5, 000001CF, FFFFFC51 with `bias_last`=1.
  - `done` one cycle later.
- **Partial last beat:** `n_out`=6 ->
  - Beat 0: mask 1111, `bias_last`=0.
  - Beat 1: mask 0011, lanes = FFFFFE8B, 00000303, 0, 0; `bias_last`=1; `rom_a3`=`rom_a4`=0.
- **Back-pressure:** `n_out`=8, `bias_ready`=0 for 5 cycles after the first valid ->
  - `bias_out` and `rom_a1`..`rom_a4` (= 4..7) stable.
  - Then 2 beats total and exactly one `done`.
- **Zero and clamp:** `n_out`=0 -> `done` at T+1, no `bias_valid`. `n_out`=200 -> same result as 128 (32 beats).
- **Ignored start / abort:** a `start` pulse mid-run is ignored (beat count unchanged). `abort` in beat 3 -> `bias_valid` low next cycle, no `done`, and a new `start` works normally.
- **Async reset:** assert `rst` between clock edges mid-run -> all outputs go to their reset values immediately. After release, a `start` produces a correct run.

Source files
------------

// File: rtl/bias_fetch_sched.sv
// Bias ROM fetch sequencer: walks the 4-port bias ROM in groups of four lanes
// up to a latched neuron count and presents each group on a valid/ready stage.
module bias_fetch_sched #(
    parameter int DEPTH = 128,
    parameter int LANES = 4,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            n_out,
    output logic [AW-1:0]         rom_a1,
    output logic [AW-1:0]         rom_a2,
    output logic [AW-1:0]         rom_a3,
    output logic [AW-1:0]         rom_a4,
    input  logic [LANES*DW-1:0]   rom_bias,
    output logic [LANES*DW-1:0]   bias_out,
    output logic [LANES-1:0]      bias_mask,
    output logic                  bias_valid,
    input  logic                  bias_ready,
    output logic                  bias_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [7:0] MAX_CNT = 8'(DEPTH);
    localparam logic [7:0] STEP    = 8'(LANES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [7:0]           r_cnt;
    logic [7:0]           r_base;
    logic [LANES*DW-1:0]  r_out;
    logic [LANES-1:0]     r_mask;
    logic                 r_valid;
    logic                 r_last;
    logic                 r_done;
    logic                 r_zero_pend;

    logic [7:0]           w_clamp;
    logic                 w_load;
    logic                 w_final;
    logic                 w_drain_hs;
    logic [LANES-1:0]     w_lane_ok;
    logic [AW-1:0]        w_addr [LANES];

    assign w_clamp    = (n_out > MAX_CNT) ? MAX_CNT : n_out;
    assign w_load     = (r_state == S_RUN) && (!r_valid || bias_ready);
    assign w_final    = (r_base + STEP) >= r_cnt;
    assign w_drain_hs = (r_state == S_DRAIN) && r_valid && bias_ready;

    // Out-of-range lanes read address 0 so the ROM never sees an illegal index.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_lane_ok[k] = (r_state == S_RUN) && ((r_base + 8'(k)) < r_cnt);
            w_addr[k]    = w_lane_ok[k] ? AW'(r_base + 8'(k)) : '0;
        end
    end

    assign rom_a1 = w_addr[0];
    assign rom_a2 = w_addr[1];
    assign rom_a3 = w_addr[2];
    assign rom_a4 = w_addr[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start && (w_clamp != 8'd0)) w_next = S_RUN;
            S_RUN:   if (w_load && w_final)          w_next = S_DRAIN;
            S_DRAIN: if (w_drain_hs)                 w_next = S_IDLE;
            default:                                 w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_base      <= '0;
            r_out       <= '0;
            r_mask      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_zero_pend <= 1'b0;
        end else if (abort) begin
            r_base      <= '0;
            r_out       <= '0;
            r_mask      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_zero_pend <= 1'b0;
        end else begin
            // A zero-length run reports done one cycle after the start is taken.
            r_done      <= r_zero_pend || w_drain_hs;
            r_zero_pend <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt       <= w_clamp;
                        r_base      <= '0;
                        r_zero_pend <= (w_clamp == 8'd0);
                    end
                end
                S_RUN: begin
                    if (w_load) begin
                        for (int k = 0; k < LANES; k++) begin
                            r_out[k*DW +: DW] <= w_lane_ok[k] ? rom_bias[k*DW +: DW] : '0;
                        end
                        r_mask  <= w_lane_ok;
                        r_valid <= 1'b1;
                        r_last  <= w_final;
                        r_base  <= r_base + STEP;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_hs) r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bias_out   = r_out;
    assign bias_mask  = r_mask;
    assign bias_valid = r_valid;
    assign bias_last  = r_last;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;

endmodule

// File: tb/tb_bias_fetch_sched.sv
// Self-checking bench for bias_fetch_sched: a ROM model feeds the DUT and a
// scoreboard queue of expected beats is checked at every handshake.
module tb_bias_fetch_sched;

    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int AW    = 7;

    localparam logic [127:0] BEAT0  = {32'h0000014C, 32'h000000CF, 32'hFFFFFA81, 32'hFFFFFCA3};
    localparam logic [127:0] BEAT31 = {32'hFFFFFC51, 32'h000001CF, 32'hFFFFFBA5, 32'hFFFFFC3A};

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic [7:0]           n_out;
    logic [AW-1:0]        rom_a1, rom_a2, rom_a3, rom_a4;
    logic [LANES*DW-1:0]  rom_bias;
    logic [LANES*DW-1:0]  bias_out;
    logic [LANES-1:0]     bias_mask;
    logic                 bias_valid;
    logic                 bias_ready;
    logic                 bias_last;
    logic                 busy;
    logic                 done;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   mask;
        logic         last;
    } beat_t;

    logic [31:0] rom [128];
    beat_t       exp_q [$];
    int          n_pass = 0;
    int          n_total = 0;
    int          beats_seen = 0;
    int          dones_seen = 0;

    bias_fetch_sched dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .n_out      (n_out),
        .rom_a1     (rom_a1),
        .rom_a2     (rom_a2),
        .rom_a3     (rom_a3),
        .rom_a4     (rom_a4),
        .rom_bias   (rom_bias),
        .bias_out   (bias_out),
        .bias_mask  (bias_mask),
        .bias_valid (bias_valid),
        .bias_ready (bias_ready),
        .bias_last  (bias_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always_comb rom_bias = {rom[rom_a4], rom[rom_a3], rom[rom_a2], rom[rom_a1]};

    task automatic init_rom();
        for (int i = 0; i < 128; i++) rom[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
        rom[0]   = 32'hFFFFFCA3; rom[1]   = 32'hFFFFFA81;
        rom[2]   = 32'h000000CF; rom[3]   = 32'h0000014C;
        rom[4]   = 32'hFFFFFE8B; rom[5]   = 32'h00000303;
        rom[124] = 32'hFFFFFC3A; rom[125] = 32'hFFFFFBA5;
        rom[126] = 32'h000001CF; rom[127] = 32'hFFFFFC51;
    endtask

    task automatic push_expected(input int n);
        int cnt;
        cnt = (n > 128) ? 128 : n;
        for (int base = 0; base < cnt; base += 4) begin
            beat_t e;
            e = '0;
            for (int k = 0; k < 4; k++) begin
                if (base + k < cnt) begin
                    e.data[k*32 +: 32] = rom[base + k];
                    e.mask[k] = 1'b1;
                end
            end
            e.last = (base + 4 >= cnt);
            exp_q.push_back(e);
        end
    endtask

    // Advance one clock; a handshake visible before the edge is scored against the queue.
    task automatic tick();
        if (!rst && bias_valid && bias_ready) begin
            beats_seen++;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL beat_unexpected: got data=%h mask=%b last=%b, expected no beat",
                         bias_out, bias_mask, bias_last);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if ({bias_out, bias_mask, bias_last} !== e)
                    $display("FAIL beat_compare: got data=%h mask=%b last=%b, expected data=%h mask=%b last=%b",
                             bias_out, bias_mask, bias_last, e.data, e.mask, e.last);
                else
                    n_pass++;
            end
        end
        @(posedge clk);
        #1;
        if (done) dones_seen++;
    endtask

    task automatic start_run(input int n);
        push_expected(n);
        n_out = 8'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_counts();
        beats_seen = 0;
        dones_seen = 0;
    endtask

    task automatic check_run_end(input string name, input int exp_beats);
        n_total++;
        if (beats_seen !== exp_beats) $display("FAIL %s_beats: got %0d expected %0d", name, beats_seen, exp_beats);
        else n_pass++;
        n_total++;
        if (dones_seen !== 1) $display("FAIL %s_done_count: got %0d expected 1", name, dones_seen);
        else n_pass++;
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL %s_queue: got %0d beats left expected 0", name, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; bias_ready = 1'b0; n_out = '0;
        #3;
        n_total++;
        if ({bias_out, bias_mask, bias_valid, bias_last, busy, done} !== '0)
            $display("FAIL reset_outputs: got out=%h mask=%b v=%b l=%b busy=%b done=%b, expected all 0",
                     bias_out, bias_mask, bias_valid, bias_last, busy, done);
        else n_pass++;
        n_total++;
        if ({rom_a1, rom_a2, rom_a3, rom_a4} !== '0)
            $display("FAIL reset_addr: got %0d %0d %0d %0d expected 0 0 0 0", rom_a1, rom_a2, rom_a3, rom_a4);
        else n_pass++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        n_total++;
        if ({bias_valid, busy, done} !== 3'b000)
            $display("FAIL reset_release: got v=%b busy=%b done=%b expected 000", bias_valid, busy, done);
        else n_pass++;
    endtask

    task automatic test_full_run(input string name, input int n);
        int first_v, nvalid, done_c;
        clear_counts();
        bias_ready = 1'b1;
        first_v = -1; nvalid = 0; done_c = -1;
        start_run(n);
        n_total++;
        if ({busy, bias_valid} !== 2'b10)
            $display("FAIL %s_start_latency: got busy=%b valid=%b expected busy=1 valid=0", name, busy, bias_valid);
        else n_pass++;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bias_valid) begin
                nvalid++;
                if (first_v < 0) first_v = c;
            end
            if (done && done_c < 0) done_c = c;
            if (c == 1) begin
                n_total++;
                if ({bias_out, bias_mask} !== {BEAT0, 4'b1111})
                    $display("FAIL %s_beat0: got %h/%b expected %h/1111", name, bias_out, bias_mask, BEAT0);
                else n_pass++;
            end
            if (c == 32) begin
                n_total++;
                if ({bias_out, bias_mask, bias_last} !== {BEAT31, 4'b1111, 1'b1})
                    $display("FAIL %s_beat31: got %h/%b last=%b expected %h/1111 last=1",
                             name, bias_out, bias_mask, bias_last, BEAT31);
                else n_pass++;
            end
        end
        n_total++;
        if (first_v !== 1) $display("FAIL %s_first_valid: got cycle %0d expected 1", name, first_v);
        else n_pass++;
        n_total++;
        if (nvalid !== 32) $display("FAIL %s_valid_cycles: got %0d expected 32", name, nvalid);
        else n_pass++;
        n_total++;
        if (done_c !== 33) $display("FAIL %s_done_cycle: got %0d expected 33", name, done_c);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s_busy_end: got %b expected 0", name, busy);
        else n_pass++;
        check_run_end(name, 32);
    endtask

    task automatic test_partial();
        clear_counts();
        bias_ready = 1'b1;
        start_run(6);
        tick();
        n_total++;
        if ({bias_mask, bias_last} !== {4'b1111, 1'b0})
            $display("FAIL partial_beat0: got mask=%b last=%b expected 1111/0", bias_mask, bias_last);
        else n_pass++;
        n_total++;
        if ({rom_a1, rom_a2, rom_a3, rom_a4} !== {7'd4, 7'd5, 7'd0, 7'd0})
            $display("FAIL partial_addr: got %0d %0d %0d %0d expected 4 5 0 0", rom_a1, rom_a2, rom_a3, rom_a4);
        else n_pass++;
        tick();
        n_total++;
        if ({bias_out, bias_mask, bias_last} !== {64'h0, 32'h00000303, 32'hFFFFFE8B, 4'b0011, 1'b1})
            $display("FAIL partial_beat1: got %h mask=%b last=%b expected 0000000000000000_00000303_FFFFFE8B/0011/1",
                     bias_out, bias_mask, bias_last);
        else n_pass++;
        for (int c = 0; c < 5; c++) tick();
        check_run_end("partial", 2);
    endtask

    task automatic test_back_pressure();
        logic [127:0] snap;
        clear_counts();
        bias_ready = 1'b0;
        start_run(8);
        tick();
        snap = bias_out;
        n_total++;
        if (bias_valid !== 1'b1) $display("FAIL bp_first_valid: got %b expected 1", bias_valid);
        else n_pass++;
        for (int c = 2; c <= 5; c++) begin
            tick();
            n_total++;
            if ({bias_out, bias_mask, bias_last, rom_a1, rom_a2, rom_a3, rom_a4} !==
                {snap, 4'b1111, 1'b0, 7'd4, 7'd5, 7'd6, 7'd7})
                $display("FAIL bp_hold_c%0d: got %h mask=%b last=%b addr=%0d,%0d,%0d,%0d expected %h/1111/0 addr=4,5,6,7",
                         c, bias_out, bias_mask, bias_last, rom_a1, rom_a2, rom_a3, rom_a4, snap);
            else n_pass++;
        end
        bias_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        check_run_end("bp", 2);
    endtask

    task automatic test_zero();
        int any_valid;
        clear_counts();
        bias_ready = 1'b1;
        any_valid = 0;
        start_run(0);
        n_total++;
        if ({done, busy} !== 2'b00) $display("FAIL zero_c0: got done=%b busy=%b expected 00", done, busy);
        else n_pass++;
        tick();
        n_total++;
        if ({done, busy, bias_valid} !== 3'b100)
            $display("FAIL zero_c1: got done=%b busy=%b valid=%b expected 100", done, busy, bias_valid);
        else n_pass++;
        for (int c = 2; c < 8; c++) begin
            tick();
            if (bias_valid || busy) any_valid++;
        end
        n_total++;
        if (any_valid !== 0) $display("FAIL zero_activity: got %0d busy/valid cycles expected 0", any_valid);
        else n_pass++;
        check_run_end("zero", 0);
    endtask

    task automatic test_ignored_start();
        clear_counts();
        bias_ready = 1'b1;
        start_run(12);
        tick();
        n_out = 8'd40;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        check_run_end("ign_start", 3);
    endtask

    task automatic test_abort();
        int late;
        clear_counts();
        bias_ready = 1'b1;
        late = 0;
        start_run(32);
        for (int c = 1; c <= 4; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_total++;
        if ({bias_valid, bias_mask, bias_last, busy} !== 7'b0)
            $display("FAIL abort_clear: got v=%b mask=%b last=%b busy=%b expected all 0",
                     bias_valid, bias_mask, bias_last, busy);
        else n_pass++;
        n_total++;
        if (exp_q.size() !== 4) $display("FAIL abort_beats_taken: got %0d left expected 4", exp_q.size());
        else n_pass++;
        exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bias_valid) late++;
        end
        n_total++;
        if ({late, dones_seen} !== {32'd0, 32'd0})
            $display("FAIL abort_quiet: got valid=%0d done=%0d expected 0 0", late, dones_seen);
        else n_pass++;
        clear_counts();
        start_run(4);
        for (int c = 0; c < 6; c++) tick();
        check_run_end("abort_restart", 1);
    endtask

    task automatic test_async_reset();
        clear_counts();
        bias_ready = 1'b1;
        start_run(64);
        for (int c = 0; c < 3; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({bias_out, bias_mask, bias_valid, bias_last, busy, done, rom_a1, rom_a2, rom_a3, rom_a4} !== '0)
            $display("FAIL async_reset: got out=%h mask=%b v=%b l=%b busy=%b done=%b expected all 0",
                     bias_out, bias_mask, bias_valid, bias_last, busy, done);
        else n_pass++;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        clear_counts();
        start_run(20);
        for (int c = 0; c < 10; c++) tick();
        check_run_end("post_reset", 5);
    endtask

    initial begin
        init_rom();
        test_reset();
        test_full_run("full", 128);
        test_partial();
        test_back_pressure();
        test_zero();
        test_full_run("clamp", 200);
        test_ignored_start();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
